text_write_scheduler: RTL



---
 rtl/text_sched_pkg.sv | 36 +++
 rtl/text_write_scheduler_cell_fifo.sv | 70 +++++++
 rtl/text_write_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/text_sched_pkg.sv
// text_sched_pkg
// Shared constants and types for the text-page write scheduler.
//   COLS/ROWS/CELLS : text geometry (80 x 60 = 4800 cells)
//   ADDR_W          : linear cell address width
//   FIFO_DEPTH      : write queue depth (power of two)
//   cell_write_t    : one queued cell write {addr, char_code, colour}
//   sched_state_t   : scheduler states IDLE / DRAIN / CLEAR
package text_sched_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 60;
  localparam int CELLS      = COLS * ROWS;
  localparam int ADDR_W     = 13;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        char_code;
    logic [7:0]        colour;
  } cell_write_t;

  localparam int CELL_W = $bits(cell_write_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } sched_state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(CELLS);
  endfunction

endpackage

// File: rtl/text_write_scheduler_cell_fifo.sv
// cell_fifo
// Small synchronous first-word-fall-through FIFO of packed cell writes.
// The head entry is visible combinationally so the scheduler can load it
// into its pending register in the cycle after the push.
// Ports:
//   clk        : clock, all state on rising edge
//   resetn     : synchronous active-low reset (empties the queue)
//   push       : write push_data (ignored when full)
//   push_data  : packed cell_write_t
//   pop        : drop head entry (ignored when empty)
//   head       : current head entry
//   full/empty : occupancy flags
module cell_fifo
  import text_sched_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [CELL_W-1:0] push_data,
  input  logic              pop,
  output logic [CELL_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CELL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_write_scheduler.sv
// text_write_scheduler
// Owns the write side of the character and colour page memories. Cell
// writes arrive over a valid/ready handshake, are queued in cell_fifo,
// moved into a single pending register and committed on any clock edge
// where the display is not reading (disp low). Optionally sequences a
// full-screen clear after draining queued writes.
// Build option: define TEXT_SCHED_CLEAR_EN to build the DRAIN/CLEAR
// sequencer; without it clr_req/clr_char/clr_colour are ignored and
// clr_busy is tied low.
// Ports:
//   CLOCK_50, resetn        : clock, synchronous active-low reset
//   disp, read_addr         : display read owns the memories while disp=1
//   wr_req/wr_addr/wr_char/wr_colour/wr_ready : write request handshake
//   clr_req/clr_char/clr_colour/clr_busy      : screen clear control
//   bad_addr                : sticky, an accepted request was out of range
//   mem_addr/mem_char_d/mem_colour_d/mem_we   : page memory write port
module text_write_scheduler
  import text_sched_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              disp,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic [7:0]        wr_colour,
  output logic              wr_ready,
  input  logic              clr_req,
  input  logic [7:0]        clr_char,
  input  logic [7:0]        clr_colour,
  output logic              clr_busy,
  output logic              bad_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_char_d,
  output logic [7:0]        mem_colour_d,
  output logic              mem_we
);

  sched_state_t      state;
  cell_write_t       pend;
  logic              pend_valid;
  logic [ADDR_W-1:0] clear_cnt;

  cell_write_t       push_cell;
  cell_write_t       head_cell;
  logic [CELL_W-1:0] fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  logic              accept;
  logic              clearing;
  logic              cur_valid;
  logic              commit;
  logic              slot_free;

  // While clearing, the counter and fill inputs stand in for the pending
  // register, so the commit path is identical for both kinds of write.
  assign clearing  = (state == CLEAR);
  assign cur_valid = pend_valid | clearing;
  assign commit    = cur_valid & ~disp;
  assign slot_free = ~pend_valid | commit;

  assign accept    = wr_req & wr_ready;
  assign push_cell = '{addr: wr_addr, char_code: wr_char, colour: wr_colour};
  // Out-of-range requests complete the handshake but never enter the queue.
  assign fifo_push = accept & addr_in_range(wr_addr);
  assign fifo_pop  = slot_free & ~fifo_empty & ~clearing;
  assign head_cell = cell_write_t'(fifo_head);

  cell_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (push_cell),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef TEXT_SCHED_CLEAR_EN
  // Full blocks acceptance even when the head is popped this same cycle.
  assign wr_ready = resetn & ~fifo_full & ~clr_busy;
`else
  logic unused_clr;
  assign unused_clr = clr_req;
  assign wr_ready   = resetn & ~fifo_full;
  assign clr_busy   = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      bad_addr   <= 1'b0;
      clear_cnt  <= '0;
`ifdef TEXT_SCHED_CLEAR_EN
      clr_busy   <= 1'b0;
`endif
    end else begin
      if (accept && !addr_in_range(wr_addr)) begin
        bad_addr <= 1'b1;
      end

      if (fifo_pop) begin
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end

`ifdef TEXT_SCHED_CLEAR_EN
      case (state)
        IDLE: begin
          // A write accepted alongside clr_req is already queued and drains first.
          if (clr_req) begin
            clr_busy <= 1'b1;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && slot_free) begin
            clear_cnt <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (commit) begin
            if (clear_cnt == LAST_CELL) begin
              clr_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              clear_cnt <= clear_cnt + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (fifo_pop) begin
      pend <= head_cell;
    end
  end

  assign mem_addr     = disp ? read_addr : (clearing ? clear_cnt : pend.addr);
  assign mem_char_d   = clearing ? clr_char : pend.char_code;
  assign mem_colour_d = clearing ? clr_colour : pend.colour;
  assign mem_we       = ~disp & cur_valid;

endmodule
